// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        S_NORM   = 1'b0,
        S_FORCE1 = 1'b1
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int unsigned MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/dmem_arb_wait_counter.sv
// Saturating count of consecutive cycles port 1 was denied; flags when the
// incremented value reaches MaxWait so the arbiter can hand port 1 priority.
module dmem_arb_wait_counter #(
    parameter int unsigned MaxWait = 4,
    parameter int unsigned CntW    = $clog2(MaxWait + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            clr_i,
    output logic [CntW-1:0] cnt_o,
    output logic            force_o
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWait);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic [CntW-1:0] cnt_inc;

    always_comb begin
        cnt_inc = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_inc;
        end
    end

    assign force_o = inc_i & ~clr_i & (cnt_inc == MaxCnt);
    assign cnt_o   = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 priority with
// starvation relief for port 1, or round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    output logic          p0_gnt_o,
    output logic          p0_stall_o,
    output logic          p0_rvalid_o,
    output logic [DW-1:0] p0_rdata_o,

    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic [DW-1:0] p1_rdata_o,

    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    logic          p0_gnt;
    logic          p1_gnt;
    logic          rd_pend_q;
    logic          rd_pend_d;
    logic          rd_owner_q;
    logic          rd_owner_d;
    logic [DW-1:0] p0_rdata_q;
    logic [DW-1:0] p1_rdata_q;

`ifdef DMEM_ARB_RR_EN
    arb_state_e state_q;
    logic       last_gnt_q;
    logic       last_gnt_d;

    assign state_q = S_NORM;

    // On contention the port that did not win last time goes first.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (p0_req_i && p1_req_i) begin
            p0_gnt = (last_gnt_q == PORT1);
            p1_gnt = (last_gnt_q == PORT0);
        end else begin
            p0_gnt = p0_req_i;
            p1_gnt = p1_req_i;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (p0_gnt_o) begin
            last_gnt_d = PORT0;
        end else if (p1_gnt_o) begin
            last_gnt_d = PORT1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q <= PORT1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    arb_state_e                          state_q;
    arb_state_e                          state_d;
    logic                                wait_inc;
    logic                                wait_clr;
    logic                                wait_force;
    logic [$clog2(MAX_WAIT + 1)-1:0]     wait_cnt;

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        unique case (state_q)
            S_FORCE1: begin
                p1_gnt = p1_req_i;
                p0_gnt = p0_req_i & ~p1_req_i;
            end
            default: begin
                p0_gnt = p0_req_i;
                p1_gnt = p1_req_i & ~p0_req_i;
            end
        endcase
    end

    assign wait_inc = p1_req_i & ~p1_gnt_o;
    assign wait_clr = ~p1_req_i | p1_gnt_o;

    dmem_arb_wait_counter #(
        .MaxWait (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (wait_inc),
        .clr_i   (wait_clr),
        .cnt_o   (wait_cnt),
        .force_o (wait_force)
    );

    always_comb begin
        state_d = state_q;
        if (wait_clr) begin
            state_d = S_NORM;
        end else if (wait_force) begin
            state_d = S_FORCE1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_NORM;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    // Grants are held low while reset is asserted, whatever the requesters do.
    assign p0_gnt_o   = p0_gnt & rst_ni;
    assign p1_gnt_o   = p1_gnt & rst_ni;
    assign p0_stall_o = p0_req_i & ~p0_gnt_o & rst_ni;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (p0_gnt_o) begin
            mem_we_o    = p0_we_i;
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
        end else if (p1_gnt_o) begin
            mem_we_o    = p1_we_i;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
        end
    end

    always_comb begin
        rd_pend_d  = (p0_gnt_o & ~p0_we_i) | (p1_gnt_o & ~p1_we_i);
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) begin
            rd_owner_d = p1_gnt_o ? PORT1 : PORT0;
        end
    end

    assign p0_rvalid_o = rd_pend_q & (rd_owner_q == PORT0);
    assign p1_rvalid_o = rd_pend_q & (rd_owner_q == PORT1);
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : p0_rdata_q;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : p1_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PORT0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            if (p0_rvalid_o) begin
                p0_rdata_q <= mem_rdata_i;
            end
            if (p1_rvalid_o) begin
                p1_rdata_q <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64x16 registered-read memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [15:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
    logic        p0_gnt_o, p0_stall_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
    logic [15:0] p0_rdata_o, p1_rdata_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [64];

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o[5:0]] <= mem_wdata_o;
        else          mem_rdata_i <= mem[mem_addr_o[5:0]];
    end

    dmem_arbiter dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .p0_req_i    (p0_req_i),
        .p0_we_i     (p0_we_i),
        .p0_addr_i   (p0_addr_i),
        .p0_wdata_i  (p0_wdata_i),
        .p0_gnt_o    (p0_gnt_o),
        .p0_stall_o  (p0_stall_o),
        .p0_rvalid_o (p0_rvalid_o),
        .p0_rdata_o  (p0_rdata_o),
        .p1_req_i    (p1_req_i),
        .p1_we_i     (p1_we_i),
        .p1_addr_i   (p1_addr_i),
        .p1_wdata_i  (p1_wdata_i),
        .p1_gnt_o    (p1_gnt_o),
        .p1_rvalid_o (p1_rvalid_o),
        .p1_rdata_o  (p1_rdata_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
        mem[5] = 16'h1234;
        mem_rdata_i = '0;
        rst_ni = 1'b0;
        p0_req_i = 0; p0_we_i = 0; p0_addr_i = '0; p0_wdata_i = '0;
        p1_req_i = 0; p1_we_i = 0; p1_addr_i = '0; p1_wdata_i = '0;

        repeat (2) next_cycle();
        settle();
        chk("rst_p0_gnt", p0_gnt_o, 0);
        chk("rst_p1_gnt", p1_gnt_o, 0);
        chk("rst_p0_rvalid", p0_rvalid_o, 0);
        chk("rst_p1_rvalid", p1_rvalid_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_p0_rdata", p0_rdata_o, 0);
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        // 1: p0 read of addr 5
        p0_req_i = 1; p0_we_i = 0; p0_addr_i = 16'd5;
        settle();
        chk("t1_p0_gnt", p0_gnt_o, 1);
        chk("t1_p0_stall", p0_stall_o, 0);
        chk("t1_mem_addr", mem_addr_o, 5);
        chk("t1_mem_we", mem_we_o, 0);
        next_cycle();
        p0_req_i = 0;
        settle();
        chk("t1_p0_rvalid", p0_rvalid_o, 1);
        chk("t1_p0_rdata", p0_rdata_o, 16'h1234);
        chk("t1_p1_rvalid", p1_rvalid_o, 0);
        next_cycle();
        settle();
        chk("t1_p0_rvalid_off", p0_rvalid_o, 0);
        chk("t1_p0_rdata_hold", p0_rdata_o, 16'h1234);
        next_cycle();

        // 2: p0 write then p1 read of the same word
        p0_req_i = 1; p0_we_i = 1; p0_addr_i = 16'd3; p0_wdata_i = 16'hBEEF;
        settle();
        chk("t2_p0_gnt", p0_gnt_o, 1);
        chk("t2_mem_we", mem_we_o, 1);
        chk("t2_mem_wdata", mem_wdata_o, 16'hBEEF);
        next_cycle();
        p0_req_i = 0; p0_we_i = 0;
        p1_req_i = 1; p1_we_i = 0; p1_addr_i = 16'd3;
        settle();
        chk("t2_p1_gnt", p1_gnt_o, 1);
        chk("t2_p0_rvalid", p0_rvalid_o, 0);
        chk("t2_mem_addr", mem_addr_o, 3);
        next_cycle();
        p1_req_i = 0;
        settle();
        chk("t2_p1_rvalid", p1_rvalid_o, 1);
        chk("t2_p1_rdata", p1_rdata_o, 16'hBEEF);
        chk("t2_p0_rdata_hold", p0_rdata_o, 16'h1234);
        next_cycle();

`ifndef DMEM_ARB_RR_EN
        // 3: both requesting continuously, port 1 forced through on cycle 4
        p0_req_i = 1; p0_addr_i = 16'd1;
        p1_req_i = 1; p1_addr_i = 16'd2;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk($sformatf("t3_p0_gnt_c%0d", i), p0_gnt_o, (i != 4) ? 1 : 0);
            chk($sformatf("t3_p1_gnt_c%0d", i), p1_gnt_o, (i == 4) ? 1 : 0);
            chk($sformatf("t3_p0_stall_c%0d", i), p0_stall_o, (i == 4) ? 1 : 0);
            next_cycle();
        end
        p0_req_i = 0; p1_req_i = 0;
        settle();
        next_cycle();

        // 4: a dropped port-1 request restarts the count
        p0_req_i = 1; p1_req_i = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk($sformatf("t4_pre_p1_gnt_c%0d", i), p1_gnt_o, 0);
            next_cycle();
        end
        p1_req_i = 0;
        settle();
        chk("t4_drop_p1_gnt", p1_gnt_o, 0);
        next_cycle();
        p1_req_i = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t4_p1_gnt_c%0d", i), p1_gnt_o, (i == 4) ? 1 : 0);
            chk($sformatf("t4_p0_stall_c%0d", i), p0_stall_o, (i == 4) ? 1 : 0);
            next_cycle();
        end
        p0_req_i = 0; p1_req_i = 0;
        settle();
        next_cycle();
`endif

        // 5: reset right after a p1 read grant drops the read
        p1_req_i = 1; p1_we_i = 0; p1_addr_i = 16'd5;
        settle();
        chk("t5_p1_gnt", p1_gnt_o, 1);
        next_cycle();
        rst_ni = 1'b0;
        p1_req_i = 0;
        settle();
        chk("t5_rst_p1_rvalid", p1_rvalid_o, 0);
        chk("t5_rst_p1_rdata", p1_rdata_o, 0);
        next_cycle();
        settle();
        chk("t5_rst2_p1_rvalid", p1_rvalid_o, 0);
        next_cycle();
        rst_ni = 1'b1;
        settle();
        chk("t5_state", dut.state_q, S_NORM);
`ifndef DMEM_ARB_RR_EN
        chk("t5_wait_cnt", dut.wait_cnt, 0);
`endif
        chk("t5_p1_rvalid", p1_rvalid_o, 0);
        chk("t5_p0_rvalid", p0_rvalid_o, 0);
        chk("t5_p0_gnt", p0_gnt_o, 0);
        chk("t5_p1_gnt", p1_gnt_o, 0);
        chk("t5_p0_stall", p0_stall_o, 0);
        chk("t5_mem_addr", mem_addr_o, 0);
        chk("t5_mem_wdata", mem_wdata_o, 0);
        chk("t5_p0_rdata", p0_rdata_o, 0);
        chk("t5_p1_rdata", p1_rdata_o, 0);
        next_cycle();
        settle();
        chk("t5_post_p1_rvalid", p1_rvalid_o, 0);
        next_cycle();

`ifdef DMEM_ARB_RR_EN
        // 6: round-robin alternation, p0 first after reset
        p0_req_i = 1; p1_req_i = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t6_p0_gnt_c%0d", i), p0_gnt_o, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("t6_p1_gnt_c%0d", i), p1_gnt_o, (i % 2 == 1) ? 1 : 0);
            next_cycle();
        end
        p0_req_i = 0; p1_req_i = 0;
        next_cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 64x16 data memory between two requesters: port 0 is the processor load/store path, port 1 is a secondary master (debug loader / DMA).
- Port 0 has fixed priority. A wait counter stops port 1 from starving.
- The block routes registered read data back to the requester that issued the read.
- It sits between the processor's data-memory interface and the data memory.

Parameters:
- AW, 16, address width passed to memory (memory itself decodes addr[5:0])
- DW, 16, data width
- MAX_WAIT, 4, consecutive denied cycles of port 1 before port 1 is forced priority (min 1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- p0_req  in  1  port 0 access request
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  AW  port 0 address
- p0_wdata  in  DW  port 0 write data
- p0_gnt  out  1  port 0 access accepted this cycle (combinational)
- p0_stall  out  1  p0_req & ~p0_gnt; processor must hold PC and instruction
- p0_rvalid  out  1  port 0 read data valid
- p0_rdata  out  DW  port 0 read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1 (no stall output)
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, registered inside memory, valid one cycle after a non-write edge

Behaviour:
- Reset (rst=0, async):
  - state=S_NORM, wait_cnt=0, rd_pend=0, rd_owner=0.
  - All gnt, rvalid and stall outputs are 0; mem_we=0; mem_addr, mem_wdata, p0_rdata and p1_rdata are 0.
  - Any in-flight read is dropped and never returns rvalid.
- FSM states: S_NORM (port 0 priority) and S_FORCE1 (port 1 priority).
- Grant, combinational from req and registered state:
  - S_NORM: p0_req wins; p1 is granted only if ~p0_req.
  - S_FORCE1: p1_req wins; p0 is granted only if ~p1_req.
  - At most one gnt per cycle.
- Memory drive:
  - Granted port's addr, wdata and we drive mem_* in the same cycle; memory samples them at the next rising edge.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A granted read sets rd_pend=1 and rd_owner=port at the edge.
  - In the following cycle, rvalid=1 for the owner only, and that owner's rdata = mem_rdata.
  - The non-owner's rdata holds its last value.
  - Latency is 1 cycle grant-to-rvalid. Back-to-back reads return one per cycle, in order.
- Writes produce no rvalid; the data is visible to a read granted one cycle later.
- Starvation counter:
  - wait_cnt increments on each cycle with p1_req & ~p1_gnt, saturating at MAX_WAIT.
  - When the incremented value equals MAX_WAIT, the next state is S_FORCE1.
  - On p1_gnt: wait_cnt=0, next state S_NORM.
  - If p1_req is low: wait_cnt=0, next state S_NORM, even if the FSM is in S_FORCE1.
- Handshake: a requester holds req and payload stable until gnt. Dropping req before gnt is legal and cancels the request.
- Simultaneous cases:
  - A grant and a returning rvalid may occur in the same cycle, for the same or different ports.
  - A write granted while a read is pending does not disturb that read's return.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- When defined: round-robin arbitration. A register last_gnt (reset 1) marks the last granted port; on contention the other port wins. The starvation counter and S_FORCE1 are not built, and the FSM is fixed at S_NORM.
- When undefined: fixed priority with starvation counter, as above.

Decomposition:
- Package dmem_arb_pkg holds: the state enum (S_NORM, S_FORCE1), port ID constants (PORT0=0, PORT1=1), and the MAX_WAIT default.
- One sub-module: dmem_arb_wait_counter, the saturating wait counter with clear and a force-request output.
- Grant logic, mux and read routing stay in the top module.

Test Plan:
1. Reset, then p0 read addr 5 with mem[5]=0x1234 -> p0_gnt=1 that cycle; next cycle p0_rvalid=1 and p0_rdata=0x1234; p1_rvalid stays 0.
2. p0 write addr 3 data 0xBEEF, then p1 read addr 3 the next cycle -> p1_gnt=1; one cycle later p1_rvalid=1 and p1_rdata=0xBEEF.
3. Both req held high, MAX_WAIT=4 -> p0_gnt cycles 0-3, p1_gnt cycle 4 with p0_stall=1 that cycle, p0_gnt again cycle 5.
4. p1 denied 2 cycles, drops req one cycle, re-requests with p0 still busy -> p1_gnt only after 4 further denied cycles.
5. rst asserted low the cycle after a p1 read grant -> p1_rvalid never asserts; after release state=S_NORM, wait_cnt=0, all outputs 0.
6. DMEM_ARB_RR_EN defined, both req held high -> grants alternate p0, p1, p0, p1; p0 gets the first grant after reset.
